// File: rtl/mdu_ctrl_pkg.sv
// Shared types, iteration constants and op-classification helpers for the multiply/divide unit.
package mdu_ctrl_pkg;

  localparam int XLEN = 64;
  typedef logic [XLEN-1:0] word_t;

  localparam int unsigned MDU_ITER_D = 64;
  localparam int unsigned MDU_ITER_W = 32;

  typedef enum logic [3:0] {
    MDU_NOP   = 4'd0,
    MDU_MUL   = 4'd1,
    MDU_MULW  = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_REM   = 4'd5,
    MDU_REMU  = 4'd6,
    MDU_DIVW  = 4'd7,
    MDU_DIVUW = 4'd8,
    MDU_REMW  = 4'd9,
    MDU_REMUW = 4'd10
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } mdu_state_t;

  function automatic logic is_w_op(mdu_op_t op);
    case (op)
      MDU_MULW, MDU_DIVW, MDU_DIVUW, MDU_REMW, MDU_REMUW: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_signed_op(mdu_op_t op);
    case (op)
      MDU_DIV, MDU_REM, MDU_DIVW, MDU_REMW: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_rem_op(mdu_op_t op);
    case (op)
      MDU_REM, MDU_REMU, MDU_REMW, MDU_REMUW: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_mul_op(mdu_op_t op);
    case (op)
      MDU_MUL, MDU_MULW: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic word_t sext32(logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  // W ops always deliver a value sign-extended from bit 31, signed or not.
  function automatic word_t fit_w(word_t v, logic w);
    return w ? sext32(v[31:0]) : v;
  endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// Execute-stage <-> multiply/divide unit request/response bundle.
interface mdu_ctrl_if;
  import mdu_ctrl_pkg::*;

  logic    start;
  mdu_op_t op;
  word_t   a;
  word_t   b;
  logic    flush;
  logic    stall;
  logic    done;
  word_t   result;

  modport master (output start, op, a, b, flush, input stall, done, result);
  modport slave  (input start, op, a, b, flush, output stall, done, result);
endinterface

// File: rtl/mdu_divcore.sv
// Restoring-divider datapath on magnitudes: one quotient bit per step, next-step values exposed.
module mdu_divcore
  import mdu_ctrl_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  load_i,
  input  logic  step_i,
  input  word_t dividend_i,
  input  word_t divisor_i,
  output word_t quo_nxt_o,
  output word_t rem_nxt_o
);

  word_t         rem_q, quo_q, dvs_q;
  logic [XLEN:0] shifted_s;
  logic          ge_s;
  word_t         diff_s;

  // Remainder stays below the divisor, so the difference always fits in XLEN bits.
  always_comb begin
    shifted_s = {rem_q, quo_q[XLEN-1]};
    ge_s      = (shifted_s >= {1'b0, dvs_q});
    diff_s    = shifted_s[XLEN-1:0] - dvs_q;
    if (ge_s) begin
      rem_nxt_o = diff_s;
    end else begin
      rem_nxt_o = shifted_s[XLEN-1:0];
    end
    quo_nxt_o = {quo_q[XLEN-2:0], ge_s};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else if (load_i) begin
      rem_q <= '0;
      quo_q <= dividend_i;
      dvs_q <= divisor_i;
    end else if (step_i) begin
      rem_q <= rem_nxt_o;
      quo_q <= quo_nxt_o;
    end
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer: FSM, iteration counter, divide special cases, sign fixup, multiplier.
// Build option MDU_FAST_MUL_EN: single-cycle multiply at accept instead of shift-add.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  mdu_ctrl_if.slave mdu
);

  mdu_state_t state_q, state_d;
  mdu_op_t    op_q, op_d;
  logic [6:0] cnt_q, cnt_d;
  logic       w_q, w_d, qneg_q, qneg_d, rneg_q, rneg_d;
  logic       done_q, done_d;
  word_t      result_q, result_d;

  logic  accept_s, req_w_s, req_sgn_s, neg_a_s, neg_b_s, div0_s, ovf_s;
  word_t a_ext_s, b_ext_s, min_s, mag_a_s, mag_b_s, div_dvd_s, spec_res_s;
  logic  div_load_s, div_step_s;
  word_t quo_nxt_s, rem_nxt_s, quo_fix_s, rem_fix_s, div_res_s;

`ifdef MDU_FAST_MUL_EN
  word_t prod_s;
  assign prod_s = mdu.a * mdu.b;
`else
  word_t mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d, acc_nxt_s;
  assign acc_nxt_s = acc_q + (mplier_q[0] ? mcand_q : 64'd0);
`endif

  assign mdu.stall  = !reset && (accept_s || (state_q == MUL) || (state_q == DIV));
  assign mdu.done   = done_q;
  assign mdu.result = result_q;

  // Operand conditioning and special-case detection for the request being offered.
  always_comb begin
    accept_s  = (state_q == IDLE) && mdu.start && (mdu.op != MDU_NOP) && !mdu.flush;
    req_w_s   = is_w_op(mdu.op);
    req_sgn_s = is_signed_op(mdu.op);
    if (req_w_s) begin
      a_ext_s = req_sgn_s ? sext32(mdu.a[31:0]) : {32'd0, mdu.a[31:0]};
      b_ext_s = req_sgn_s ? sext32(mdu.b[31:0]) : {32'd0, mdu.b[31:0]};
      min_s   = sext32(32'h8000_0000);
    end else begin
      a_ext_s = mdu.a;
      b_ext_s = mdu.b;
      min_s   = {1'b1, 63'd0};
    end
    neg_a_s   = req_sgn_s && a_ext_s[63];
    neg_b_s   = req_sgn_s && b_ext_s[63];
    mag_a_s   = neg_a_s ? (64'd0 - a_ext_s) : a_ext_s;
    mag_b_s   = neg_b_s ? (64'd0 - b_ext_s) : b_ext_s;
    div_dvd_s = req_w_s ? {mag_a_s[31:0], 32'd0} : mag_a_s;
    div0_s    = (b_ext_s == 64'd0);
    ovf_s     = req_sgn_s && (a_ext_s == min_s) && (b_ext_s == {64{1'b1}});
    if (div0_s) begin
      spec_res_s = is_rem_op(mdu.op) ? fit_w(mdu.a, req_w_s) : {64{1'b1}};
    end else begin
      spec_res_s = is_rem_op(mdu.op) ? 64'd0 : a_ext_s;
    end
  end

  // Sign fixup of the final divide step.
  always_comb begin
    quo_fix_s = qneg_q ? (64'd0 - quo_nxt_s) : quo_nxt_s;
    rem_fix_s = rneg_q ? (64'd0 - rem_nxt_s) : rem_nxt_s;
    div_res_s = fit_w(is_rem_op(op_q) ? rem_fix_s : quo_fix_s, w_q);
  end

  mdu_divcore u_divcore (
    .clk        (clk),
    .reset      (reset),
    .load_i     (div_load_s),
    .step_i     (div_step_s),
    .dividend_i (div_dvd_s),
    .divisor_i  (mag_b_s),
    .quo_nxt_o  (quo_nxt_s),
    .rem_nxt_o  (rem_nxt_s)
  );

  // Next-state logic; flush overrides everything and leaves result untouched.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    w_d        = w_q;
    qneg_d     = qneg_q;
    rneg_d     = rneg_q;
    done_d     = 1'b0;
    result_d   = result_q;
    div_load_s = 1'b0;
    div_step_s = 1'b0;
`ifndef MDU_FAST_MUL_EN
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    acc_d      = acc_q;
`endif
    if (mdu.flush) begin
      state_d = IDLE;
      cnt_d   = 7'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_s) begin
            op_d   = mdu.op;
            w_d    = req_w_s;
            qneg_d = neg_a_s ^ neg_b_s;
            rneg_d = neg_a_s;
            cnt_d  = req_w_s ? 7'(MDU_ITER_W) : 7'(MDU_ITER_D);
            if (is_mul_op(mdu.op)) begin
`ifdef MDU_FAST_MUL_EN
              result_d = fit_w(prod_s, req_w_s);
              done_d   = 1'b1;
              cnt_d    = 7'd0;
              state_d  = DONE;
`else
              mcand_d  = mdu.a;
              mplier_d = mdu.b;
              acc_d    = 64'd0;
              state_d  = MUL;
`endif
            end else if (div0_s || ovf_s) begin
              result_d = spec_res_s;
              done_d   = 1'b1;
              cnt_d    = 7'd0;
              state_d  = DONE;
            end else begin
              div_load_s = 1'b1;
              state_d    = DIV;
            end
          end else begin
            state_d = IDLE;
          end
        end
        MUL: begin
`ifdef MDU_FAST_MUL_EN
          state_d = IDLE;
`else
          acc_d    = acc_nxt_s;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q - 7'd1;
          if (cnt_q == 7'd1) begin
            result_d = fit_w(acc_nxt_s, w_q);
            done_d   = 1'b1;
            state_d  = DONE;
          end else begin
            state_d = MUL;
          end
`endif
        end
        DIV: begin
          div_step_s = 1'b1;
          cnt_d      = cnt_q - 7'd1;
          if (cnt_q == 7'd1) begin
            result_d = div_res_s;
            done_d   = 1'b1;
            state_d  = DONE;
          end else begin
            state_d = DIV;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= MDU_NOP;
      cnt_q    <= 7'd0;
      w_q      <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= 64'd0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      w_q      <= w_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

`ifndef MDU_FAST_MUL_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_q  <= 64'd0;
      mplier_q <= 64'd0;
      acc_q    <= 64'd0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end
`endif

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed corner cases plus randomized ops vs. an arithmetic model.
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;

`ifdef MDU_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic  clk = 1'b0;
  logic  reset;
  int    checks = 0;
  int    failures = 0;
  word_t last_res;

  mdu_ctrl_if bus ();

  mdu_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .mdu   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_is_w(mdu_op_t op);
    return op inside {MDU_MULW, MDU_DIVW, MDU_DIVUW, MDU_REMW, MDU_REMUW};
  endfunction

  function automatic int ref_latency(mdu_op_t op, word_t a, word_t b);
    bit w, sgn, zero, ovf;
    w    = ref_is_w(op);
    sgn  = op inside {MDU_DIV, MDU_REM, MDU_DIVW, MDU_REMW};
    zero = w ? (b[31:0] == 32'd0) : (b == 64'd0);
    ovf  = sgn && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                     : (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF));
    if (op == MDU_MUL || op == MDU_MULW) return FAST ? 1 : (w ? 33 : 65);
    if (zero || ovf) return 1;
    return w ? 33 : 65;
  endfunction

  function automatic word_t ref_model(mdu_op_t op, word_t a, word_t b);
    longint      sa, sb;
    int          sa32, sb32;
    logic [31:0] ua32, ub32, r32;
    word_t       r;
    bit          ovf64, ovf32;
    sa = a; sb = b; sa32 = a[31:0]; sb32 = b[31:0]; ua32 = a[31:0]; ub32 = b[31:0];
    ovf64 = (a == 64'h8000_0000_0000_0000) && (b == 64'hFFFF_FFFF_FFFF_FFFF);
    ovf32 = (ua32 == 32'h8000_0000) && (ub32 == 32'hFFFF_FFFF);
    r = 64'd0; r32 = 32'd0;
    case (op)
      MDU_MUL:  r = a * b;
      MDU_DIV:  if (b == 64'd0) r = '1; else if (ovf64) r = a; else r = sa / sb;
      MDU_DIVU: if (b == 64'd0) r = '1; else r = a / b;
      MDU_REM:  if (b == 64'd0) r = a; else if (ovf64) r = 64'd0; else r = sa % sb;
      MDU_REMU: if (b == 64'd0) r = a; else r = a % b;
      MDU_MULW:  r32 = ua32 * ub32;
      MDU_DIVW:  if (ub32 == 32'd0) r32 = '1; else if (ovf32) r32 = ua32; else r32 = sa32 / sb32;
      MDU_DIVUW: if (ub32 == 32'd0) r32 = '1; else r32 = ua32 / ub32;
      MDU_REMW:  if (ub32 == 32'd0) r32 = ua32; else if (ovf32) r32 = 32'd0; else r32 = sa32 % sb32;
      MDU_REMUW: if (ub32 == 32'd0) r32 = ua32; else r32 = ua32 % ub32;
      default:   r = 64'd0;
    endcase
    if (ref_is_w(op)) r = {{32{r32[31]}}, r32};
    return r;
  endfunction

  // Called at posedge+1 of the cycle in which the request is offered (cycle 0).
  task automatic run_op(input mdu_op_t op, input word_t a, input word_t b,
                        input word_t exp, input string tag);
    int lat, stall_cnt, exp_lat;
    exp_lat = ref_latency(op, a, b);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    #1;
    check({tag, "_stall_c0"}, bus.stall, 1'b1);
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 1; stall_cnt = 0;
    while (!bus.done && lat < 200) begin
      if (bus.stall) stall_cnt++;
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_stall_cycles"}, stall_cnt, exp_lat - 1);
    check({tag, "_result"}, bus.result, exp);
    check({tag, "_stall_done"}, bus.stall, 1'b0);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, bus.done, 1'b0);
    check({tag, "_result_held"}, bus.result, exp);
    last_res = exp;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit      saw;
    mdu_op_t rop;
    word_t   ra, rb;
    int      sel;

    reset = 1'b1; bus.start = 1'b1; bus.op = MDU_DIV; bus.a = 64'd9; bus.b = 64'd3; bus.flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_stall", bus.stall, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_result", bus.result, 64'd0);
    reset = 1'b0; bus.start = 1'b0;
    @(posedge clk); #1;
    check("idle_stall", bus.stall, 1'b0);
    check("idle_done", bus.done, 1'b0);
    last_res = 64'd0;

    run_op(MDU_DIV,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, "div_m7_2");
    run_op(MDU_REM,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, "rem_m7_2");
    run_op(MDU_DIVU, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, "divu_by0");
    run_op(MDU_REMU, 64'd5, 64'd0, 64'd5, "remu_by0");
    run_op(MDU_DIV,  64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, "div_ovf");
    run_op(MDU_REM,  64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, "rem_ovf");
    run_op(MDU_DIVW, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, "divw_ovf");
    run_op(MDU_REMUW, 64'h1234_5678_8000_0005, 64'hABCD_0000_0000_0000, 64'hFFFF_FFFF_8000_0005, "remuw_by0");
    run_op(MDU_MULW, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, "mulw");

    // Flush and start together in IDLE: flush wins, nothing is accepted.
    bus.start = 1'b1; bus.op = MDU_DIVU; bus.a = 64'd5; bus.b = 64'd0; bus.flush = 1'b1;
    #1;
    check("flush_start_stall", bus.stall, 1'b0);
    @(posedge clk); #1;
    bus.start = 1'b0; bus.flush = 1'b0;
    check("flush_start_stall_c1", bus.stall, 1'b0);
    check("flush_start_done_c1", bus.done, 1'b0);
    @(posedge clk); #1;
    check("flush_start_done_c2", bus.done, 1'b0);

    // Flush at cycle 10 of a DIVU, then restart at cycle 11.
    bus.start = 1'b1; bus.op = MDU_DIVU; bus.a = 64'd100; bus.b = 64'd7;
    @(posedge clk); #1;
    bus.start = 1'b0; saw = 1'b0;
    repeat (9) begin
      if (bus.done) saw = 1'b1;
      @(posedge clk); #1;
    end
    if (bus.done) saw = 1'b1;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check("flush_no_done", {saw, bus.done}, 2'b00);
    check("flush_stall_k1", bus.stall, 1'b0);
    check("flush_result_kept", bus.result, last_res);
    run_op(MDU_DIVU, 64'd100, 64'd7, 64'd14, "divu_after_flush");

    // Reset at cycle 20 of a long operation.
    bus.start = 1'b1; bus.op = FAST ? MDU_DIVU : MDU_MUL; bus.a = 64'd12345; bus.b = 64'd678;
    @(posedge clk); #1;
    bus.start = 1'b0; saw = 1'b0;
    repeat (19) begin
      if (bus.done) saw = 1'b1;
      @(posedge clk); #1;
    end
    reset = 1'b1;
    #1;
    check("rst_mid_stall_high", bus.stall, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst_mid_result", bus.result, 64'd0);
    check("rst_mid_stall", bus.stall, 1'b0);
    repeat (70) begin
      if (bus.done) saw = 1'b1;
      @(posedge clk); #1;
    end
    check("rst_mid_no_done", saw, 1'b0);
    run_op(MDU_MUL, 64'd3, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFF4, "mul_3_m4");

    for (int i = 0; i < 24; i++) begin
      rop = mdu_op_t'(4'($urandom_range(1, 10)));
      ra  = {$urandom, $urandom};
      sel = $urandom_range(0, 4);
      case (sel)
        0: rb = {$urandom, $urandom};
        1: rb = 64'($urandom_range(0, 3));
        2: rb = 64'd0 - 64'($urandom_range(1, 3));
        3: rb = {32'd0, $urandom};
        default: begin
          ra = ref_is_w(rop) ? 64'h0000_0000_8000_0000 : 64'h8000_0000_0000_0000;
          rb = 64'hFFFF_FFFF_FFFF_FFFF;
        end
      endcase
      run_op(rop, ra, rb, ref_model(rop, ra, rb), $sformatf("rand%0d_op%0d", i, rop));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
